// File: rtl/rvv_alu_seq.sv
// Multi-lane sequential vector integer ALU: one whole-register instruction in, NB_LANES elements per cycle, VLEN-bit vd out.
// Optional mask-undisturbed merge of body elements against v0 is enabled with RVV_ALU_SEQ_MASK_EN.
module rvv_alu_seq #(
   parameter int VLEN     = 128,
   parameter int NB_LANES = 4,
   parameter int ELEN     = 64
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               opcode,
   input  logic [2:0]               op_type,
   input  logic [2:0]               vsew,
   input  logic [$clog2(VLEN/8):0]  vl,
   input  logic [VLEN-1:0]          vs1,
   input  logic [VLEN-1:0]          vs2,
   input  logic [VLEN-1:0]          vd_old,
   input  logic [ELEN-1:0]          rs1,
   input  logic [4:0]               imm,
   input  logic                     vm,
   input  logic [VLEN-1:0]          v0,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [VLEN-1:0]          vd,
   output logic                     illegal
);
   localparam int VLW = $clog2(VLEN/8) + 1;
   localparam int IW  = VLW + $clog2(NB_LANES) + 1;
   localparam int PW  = IW + 6;

   localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000010, OP_RSUB = 6'b000011,
                          OP_MINU = 6'b000100, OP_MIN = 6'b000101, OP_MAXU = 6'b000110,
                          OP_MAX = 6'b000111, OP_AND = 6'b001001, OP_OR = 6'b001010,
                          OP_XOR = 6'b001011, OP_SLL = 6'b100101, OP_SRL = 6'b101000,
                          OP_SRA = 6'b101001;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} t_state;

   t_state            r_state;
   logic [5:0]        r_op;
   logic [2:0]        r_type;
   logic [1:0]        r_sew;
   logic [VLW-1:0]    r_vlm;
   logic [IW-1:0]     r_idx;
   logic [VLEN-1:0]   r_vs1, r_vs2, r_vd;
   logic [ELEN-1:0]   r_rs1;
   logic [4:0]        r_imm;
   logic              r_out_valid, r_illegal;
`ifdef RVV_ALU_SEQ_MASK_EN
   logic              r_vm;
   logic [VLEN-1:0]   r_v0;
`else
   logic              w_unused;
   assign w_unused = ^{vm, v0};
`endif

   function automatic logic [ELEN-1:0] f_mask(input logic [1:0] s);
      case (s)
         2'd0:    return ELEN'({8{1'b1}});
         2'd1:    return ELEN'({16{1'b1}});
         2'd2:    return ELEN'({32{1'b1}});
         default: return {ELEN{1'b1}};
      endcase
   endfunction

   // Operands arrive zero-extended to ELEN; sign extension is applied only where a compare or sra needs it.
   function automatic logic [ELEN-1:0] f_sext(input logic [ELEN-1:0] x, input logic [1:0] s);
      logic sg;
      case (s)
         2'd0:    sg = x[7];
         2'd1:    sg = x[15];
         2'd2:    sg = x[31];
         default: sg = x[ELEN-1];
      endcase
      return sg ? (x | ~f_mask(s)) : x;
   endfunction

   function automatic logic [ELEN-1:0] f_alu(input logic [5:0] op, input logic [ELEN-1:0] a,
                                             input logic [ELEN-1:0] b, input logic [1:0] s);
      logic [ELEN-1:0] as, bs;
      logic [5:0]      sh;
      as = f_sext(a, s);
      bs = f_sext(b, s);
      case (s)
         2'd0:    sh = b[5:0] & 6'd7;
         2'd1:    sh = b[5:0] & 6'd15;
         2'd2:    sh = b[5:0] & 6'd31;
         default: sh = b[5:0];
      endcase
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_RSUB: return b - a;
         OP_MINU: return (a < b) ? a : b;
         OP_MIN:  return ($signed(as) < $signed(bs)) ? a : b;
         OP_MAXU: return (a > b) ? a : b;
         OP_MAX:  return ($signed(as) > $signed(bs)) ? a : b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return $signed(as) >>> sh;
         default: return '0;
      endcase
   endfunction

   logic            w_op_ok, w_type_ok, w_legal, w_is_shift, w_last;
   logic [VLW-1:0]  w_vlmax;
   logic [IW-1:0]   w_idx_next;
   logic [ELEN-1:0] w_mask;
   logic [VLEN-1:0] w_vd_next;
   logic [VLEN-1:0] w_wmask [NB_LANES];
   logic [VLEN-1:0] w_wdata [NB_LANES];
   logic            w_act   [NB_LANES];

   always_comb begin
      w_op_ok = 1'b0;
      case (opcode)
         OP_ADD, OP_MINU, OP_MIN, OP_MAXU, OP_MAX, OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SRL, OP_SRA: w_op_ok = 1'b1;
         OP_SUB, OP_RSUB:        w_op_ok = (op_type != 3'b100);
         default:                w_op_ok = 1'b0;
      endcase
   end

   assign w_type_ok  = (op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100);
   assign w_legal    = w_op_ok && w_type_ok && !vsew[2];
   assign w_vlmax    = VLW'((VLEN/8) >> vsew[1:0]);
   assign w_is_shift = (r_op == OP_SLL) || (r_op == OP_SRL) || (r_op == OP_SRA);
   assign w_mask     = f_mask(r_sew);
   assign w_idx_next = r_idx + IW'(NB_LANES);
   assign w_last     = w_idx_next >= IW'(r_vlm);

   genvar gi;
   generate
      for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
         logic [IW-1:0]   w_elem;
         logic [PW-1:0]   w_pos;
         logic [ELEN-1:0] w_a, w_braw, w_b, w_res;
         logic            w_body;
         assign w_elem = r_idx + IW'(gi);
         assign w_pos  = PW'(w_elem) << ({1'b0, r_sew} + 3'd3);
         assign w_a    = ELEN'(r_vs2 >> w_pos) & w_mask;
         always_comb begin
            case (r_type)
               3'b001:  w_braw = ELEN'(r_vs1 >> w_pos);
               3'b010:  w_braw = r_rs1;
               default: w_braw = w_is_shift ? ELEN'(r_imm) : {{(ELEN-5){r_imm[4]}}, r_imm};
            endcase
         end
         assign w_b    = w_braw & w_mask;
         assign w_res  = f_alu(r_op, w_a, w_b, r_sew) & w_mask;
         assign w_body = w_elem < IW'(r_vlm);
`ifdef RVV_ALU_SEQ_MASK_EN
         assign w_act[gi] = w_body && (r_vm || 1'(r_v0 >> w_elem));
`else
         assign w_act[gi] = w_body;
`endif
         assign w_wmask[gi] = VLEN'(w_mask) << w_pos;
         assign w_wdata[gi] = VLEN'(w_res) << w_pos;
      end
   endgenerate

   always_comb begin
      w_vd_next = r_vd;
      for (int k = 0; k < NB_LANES; k++)
         if (w_act[k]) w_vd_next = (w_vd_next & ~w_wmask[k]) | w_wdata[k];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_type      <= '0;
         r_sew       <= '0;
         r_vlm       <= '0;
         r_idx       <= '0;
         r_vs1       <= '0;
         r_vs2       <= '0;
         r_vd        <= '0;
         r_rs1       <= '0;
         r_imm       <= '0;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
`ifdef RVV_ALU_SEQ_MASK_EN
         r_vm        <= 1'b1;
         r_v0        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_op      <= opcode;
               r_type    <= op_type;
               r_sew     <= vsew[1:0];
               r_vlm     <= (vl < w_vlmax) ? vl : w_vlmax;
               r_idx     <= '0;
               r_vs1     <= vs1;
               r_vs2     <= vs2;
               r_vd      <= vd_old;
               r_rs1     <= rs1;
               r_imm     <= imm;
               r_illegal <= !w_legal;
`ifdef RVV_ALU_SEQ_MASK_EN
               r_vm      <= vm;
               r_v0      <= v0;
`endif
               if (!w_legal || vl == '0) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               r_vd  <= w_vd_next;
               r_idx <= w_idx_next;
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign vd        = r_vd;
   assign illegal   = r_illegal;
endmodule
